// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with an IDLE/WAIT/RESP handshake.
// Defining DMEM_BYTE_EN_EN adds the req_be byte-enable input for writes.
module dmem_responder #(
   parameter int DEPTH = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
   input  logic [3:0]  req_be,
`endif
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_n;
   logic [3:0] cnt;
   logic we_q, err_q, accept, enter, c_we, c_err;
   logic [31:0] addr_q, wdata_q, rdata_q, c_addr, c_wdata, c_mask;
   logic [AW-1:0] c_idx;
   logic [31:0] mem [DEPTH];
`ifdef DMEM_BYTE_EN_EN
   logic [3:0] be_q, c_be;
`endif
   assign req_ready = state == IDLE;
   assign accept = req_valid && req_ready;
   assign resp_valid = state == RESP;
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err = resp_valid && err_q;
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (req_valid ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE) :
                state == WAIT ? (cnt == 0 ? RESP : WAIT) : IDLE;
   end
   assign enter = state_n == RESP && state != RESP;
   // With no wait state the commit edge is the acceptance edge, so use the live request.
   assign c_we = req_ready ? req_we : we_q;
   assign c_addr = req_ready ? req_addr : addr_q;
   assign c_wdata = req_ready ? req_wdata : wdata_q;
   assign c_idx = c_addr[AW+1:2];
   assign c_err = (c_addr[1:0] != 2'b00) || ((c_addr >> (AW + 2)) != 32'd0);
`ifdef DMEM_BYTE_EN_EN
   assign c_be = req_ready ? req_be : be_q;
   assign c_mask = {{8{c_be[3]}}, {8{c_be[2]}}, {8{c_be[1]}}, {8{c_be[0]}}};
`else
   assign c_mask = '1;
`endif
   always_ff @(posedge clk)
      if (!reset) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q <= 1'b0;
`ifdef DMEM_BYTE_EN_EN
         be_q <= '0;
`endif
      end else begin
         if (accept) begin
            we_q <= req_we;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
            cnt <= 4'(WAIT_CYCLES - 1);
`ifdef DMEM_BYTE_EN_EN
            be_q <= req_be;
`endif
         end else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
         if (enter) begin
            err_q <= c_err;
            rdata_q <= (c_we || c_err) ? '0 : mem[c_idx];
         end
      end
   end
   always_ff @(posedge clk)
      if (reset && enter && c_we && !c_err) mem[c_idx] <= (mem[c_idx] & ~c_mask) | (c_wdata & c_mask);
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios on a 2-wait-state instance (dut) and a zero-wait instance (dut0).
module tb_dmem_responder;
   logic clk, reset;
   logic valid, ready, we, rv, err;
   logic [31:0] addr, wdata, rdata;
   logic valid0, ready0, we0, rv0, err0;
   logic [31:0] addr0, wdata0, rdata0;
`ifdef DMEM_BYTE_EN_EN
   logic [3:0] be, be0;
`endif
   int total = 0;
   int bad = 0;

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(valid), .req_ready(ready), .req_we(we),
      .req_addr(addr), .req_wdata(wdata),
`ifdef DMEM_BYTE_EN_EN
      .req_be(be),
`endif
      .resp_valid(rv), .resp_rdata(rdata), .resp_err(err));

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(ready0), .req_we(we0),
      .req_addr(addr0), .req_wdata(wdata0),
`ifdef DMEM_BYTE_EN_EN
      .req_be(be0),
`endif
      .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic do_req(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] d, output logic e, output int lat);
      @(negedge clk);
      if (sel) begin valid0 = 1; we0 = w; addr0 = a; wdata0 = wd; end
      else begin valid = 1; we = w; addr = a; wdata = wd; end
      for (int i = 0; i < 20 && !(sel ? ready0 : ready); i++) @(negedge clk);
      @(posedge clk); #1;
      valid = 0; valid0 = 0;
      lat = -1; d = 'x; e = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (sel ? rv0 : rv) begin
            lat = n; d = sel ? rdata0 : rdata; e = sel ? err0 : err;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(posedge clk); @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready); end
      total++; if (rv !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rv); end
      total++; if (rdata !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL rst_resp: rdata=%h err=%b want 0/0", rdata, err); end
      total++; if (ready0 !== 1'b1 || rv0 !== 1'b0) begin bad++; $display("FAIL rst_dut0: ready=%b valid=%b want 1/0", ready0, rv0); end
      reset = 1;
      @(negedge clk);
      total++; if (rv !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL idle_resp: valid=%b rdata=%h want 0/0", rv, rdata); end
   endtask

   task automatic test_write_read;
      logic [31:0] d; logic e; int lat;
      do_req(0, 1, 32'h10, 32'hDEADBEEF, d, e, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL wr_lat: got %0d want 3", lat); end
      total++; if (e !== 1'b0 || d !== 32'h0) begin bad++; $display("FAIL wr_resp: err=%b rdata=%h want 0/0", e, d); end
      do_req(0, 0, 32'h10, 32'h0, d, e, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL rd_lat: got %0d want 3", lat); end
      total++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL rd_data: got %h err=%b want deadbeef/0", d, e); end
      @(negedge clk);
      total++; if (rv !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL after_resp: valid=%b ready=%b want 0/1", rv, ready); end
   endtask

   task automatic test_misaligned;
      logic [31:0] d; logic e; int lat;
      do_req(0, 1, 32'h4, 32'hCAFEF00D, d, e, lat);
      do_req(0, 0, 32'h6, 32'h0, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'h0 || lat !== 3) begin bad++; $display("FAIL mis_rd: err=%b rdata=%h lat=%0d want 1/0/3", e, d, lat); end
      do_req(0, 1, 32'h5, 32'h99999999, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL mis_wr: err=%b rdata=%h want 1/0", e, d); end
      do_req(0, 0, 32'h4, 32'h0, d, e, lat);
      total++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin bad++; $display("FAIL mis_word1: got %h err=%b want cafef00d/0", d, e); end
   endtask

   task automatic test_out_of_range;
      logic [31:0] d; logic e; int lat;
      do_req(0, 1, 32'h0, 32'h0BADC0DE, d, e, lat);
      do_req(0, 1, 32'h100, 32'hFFFFFFFF, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL oor_wr: err=%b rdata=%h want 1/0", e, d); end
      do_req(0, 0, 32'h0, 32'h0, d, e, lat);
      total++; if (d !== 32'h0BADC0DE || e !== 1'b0) begin bad++; $display("FAIL oor_mem0: got %h err=%b want 0badc0de/0", d, e); end
      do_req(0, 0, 32'h80000000, 32'h0, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL oor_hi: err=%b rdata=%h want 1/0", e, d); end
      do_req(0, 1, 32'hFC, 32'h600DF00D, d, e, lat);
      total++; if (e !== 1'b0) begin bad++; $display("FAIL last_wr: err=%b want 0", e); end
      do_req(0, 0, 32'hFC, 32'h0, d, e, lat);
      total++; if (d !== 32'h600DF00D || e !== 1'b0) begin bad++; $display("FAIL last_rd: got %h err=%b want 600df00d/0", d, e); end
   endtask

   task automatic test_ignore_busy;
      logic [31:0] d; logic e; int lat;
      @(negedge clk); valid = 1; we = 0; addr = 32'h10;
      @(posedge clk); #1; we = 1; addr = 32'h10; wdata = 32'h0;
      lat = -1; d = 'x; e = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rv) begin lat = n; d = rdata; e = err; valid = 0; break; end
      end
      valid = 0;
      total++; if (lat !== 3 || d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("FAIL busy_rd: lat=%0d rdata=%h err=%b want 3/deadbeef/0", lat, d, e); end
      do_req(0, 0, 32'h10, 32'h0, d, e, lat);
      total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL busy_mem: got %h want deadbeef", d); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); valid = 1; we = 0; addr = 32'h10;
      for (int c = 0; c < 9; c++) begin
         total++;
         if (ready !== (c % 4 == 0) || rv !== (c % 4 == 3) || (c == 3 && rdata !== 32'hDEADBEEF) || (c == 7 && rdata !== 32'hCAFEF00D)) begin
            bad++; $display("FAIL b2b cyc%0d: ready=%b valid=%b rdata=%h want ready=%b valid=%b", c, ready, rv, rdata, c % 4 == 0, c % 4 == 3);
         end
         @(posedge clk); #1;
         if (c == 0) addr = 32'h4;
         if (c == 4) valid = 0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_abort;
      logic [31:0] d; logic e; int lat; bit seen;
      do_req(0, 1, 32'h4, 32'h12345678, d, e, lat);
      @(negedge clk); valid = 1; we = 1; addr = 32'h4; wdata = 32'h55AA55AA;
      @(posedge clk); #1; valid = 0;
      @(negedge clk);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_wait: ready=%b want 0", ready); end
      reset = 0;
      @(posedge clk); #1; reset = 1;
      @(negedge clk);
      total++; if (ready !== 1'b1 || rv !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL abort_idle: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", ready, rv, rdata, err); end
      seen = 0;
      repeat (4) begin @(negedge clk); if (rv) seen = 1; end
      total++; if (seen) begin bad++; $display("FAIL abort_resp: got a resp_valid want none"); end
      do_req(0, 0, 32'h4, 32'h0, d, e, lat);
      total++; if (d !== 32'h12345678 || e !== 1'b0) begin bad++; $display("FAIL abort_mem: got %h err=%b want 12345678/0", d, e); end
   endtask

   task automatic test_zero_wait;
      logic [31:0] d; logic e; int lat;
      do_req(1, 1, 32'h0, 32'hA0A0A0A0, d, e, lat);
      total++; if (lat !== 1 || e !== 1'b0) begin bad++; $display("FAIL zw_lat: lat=%0d err=%b want 1/0", lat, e); end
      do_req(1, 1, 32'h4, 32'hB1B1B1B1, d, e, lat);
      do_req(1, 1, 32'h8, 32'hC2C2C2C2, d, e, lat);
      @(negedge clk); valid0 = 1; we0 = 0; addr0 = 32'h0;
      for (int c = 0; c < 7; c++) begin
         total++;
         if (ready0 !== (c % 2 == 0) || rv0 !== (c % 2 == 1) || (c == 1 && rdata0 !== 32'hA0A0A0A0) ||
             (c == 3 && rdata0 !== 32'hB1B1B1B1) || (c == 5 && rdata0 !== 32'hC2C2C2C2)) begin
            bad++; $display("FAIL zw_hold cyc%0d: ready=%b valid=%b rdata=%h want ready=%b valid=%b", c, ready0, rv0, rdata0, c % 2 == 0, c % 2 == 1);
         end
         @(posedge clk); #1;
         if (c == 0) addr0 = 32'h4;
         if (c == 2) addr0 = 32'h8;
         if (c == 4) valid0 = 0;
         @(negedge clk);
      end
   endtask

`ifdef DMEM_BYTE_EN_EN
   task automatic test_byte_en;
      logic [31:0] d; logic e; int lat;
      be = 4'hF; do_req(0, 1, 32'h20, 32'h11223344, d, e, lat);
      be = 4'b0101; do_req(0, 1, 32'h20, 32'hAABBCCDD, d, e, lat);
      be = 4'b0000; do_req(0, 0, 32'h20, 32'h0, d, e, lat);
      total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL be_mix: got %h want 11bb33dd", d); end
      do_req(0, 1, 32'h20, 32'hFFFFFFFF, d, e, lat);
      total++; if (e !== 1'b0) begin bad++; $display("FAIL be_noop_err: err=%b want 0", e); end
      be = 4'hF; do_req(0, 0, 32'h20, 32'h0, d, e, lat);
      total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL be_noop: got %h want 11bb33dd", d); end
   endtask
`endif

   initial begin
      reset = 0;
      valid = 0; we = 0; addr = 0; wdata = 0;
      valid0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
`ifdef DMEM_BYTE_EN_EN
      be = 4'hF; be0 = 4'hF;
`endif
      test_reset();
      test_write_read();
      test_misaligned();
      test_out_of_range();
      test_ignore_busy();
      test_back_to_back();
      test_reset_abort();
      test_zero_wait();
`ifdef DMEM_BYTE_EN_EN
      test_byte_en();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
